// File: rtl/uart_tx_if.sv
// Bus-side signal bundle for uart_tx: CPU write path, interrupt control and line/status outputs.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       we;
  logic       ien;
  logic       ack;
  logic       tx;
  logic       busy;
  logic       full;
  logic       overrun;
  logic       irq;

  modport master (
    output tx_data, we, ien, ack,
    input  tx, busy, full, overrun, irq
  );

  modport slave (
    input  tx_data, we, ien, ack,
    output tx, busy, full, overrun, irq
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1 LSB-first UART transmitter fed by a small circular write FIFO; frames are sent back-to-back
// while bytes remain queued, with a sticky interrupt when the line drains to idle.
module uart_tx #(
  parameter int unsigned WAIT_COUNT = 868,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned WW = $clog2(WAIT_COUNT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_COUNT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q, state_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [WW-1:0] wait_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q, busy_q, full_q, overrun_q, irq_q;
  logic          bit_end, push, pop, idle_ev;

  // Push is gated by the registered full flag, so a write into a full FIFO is dropped
  // even when the FSM pops on the same edge.
  always_comb begin
    bit_end = (wait_q == WAIT_LAST);
    push    = bus.we && !full_q;
    pop     = (count_q != '0) && ((state_q == IDLE) || ((state_q == STOP) && bit_end));
    idle_ev = (state_q == STOP) && bit_end && (count_q == '0);

    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    state_d = state_q;
    case (state_q)
      IDLE:  if (pop) state_d = START;
      START: if (bit_end) state_d = DATA;
      DATA:  if (bit_end && (bit_q == 3'd7)) state_d = STOP;
      STOP:  if (bit_end) state_d = pop ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.tx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      wait_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_C);
      busy_q  <= (state_d != IDLE) || (count_d != '0);
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);

      if (bus.we && full_q) overrun_q <= 1'b1;
      else if (bus.ack)     overrun_q <= 1'b0;
      if (idle_ev && bus.ien) irq_q <= 1'b1;
      else if (bus.ack)       irq_q <= 1'b0;

      case (state_q)
        IDLE: begin
          wait_q <= '0;
          tx_q   <= !pop;
          if (pop) shift_q <= mem_q[rptr_q];
        end
        START: begin
          if (bit_end) begin
            wait_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
          end else begin
            wait_q <= wait_q + WW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            wait_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            wait_q <= wait_q + WW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            wait_q <= '0;
            tx_q   <= !pop;
            if (pop) shift_q <= mem_q[rptr_q];
          end else begin
            wait_q <= wait_q + WW'(1);
          end
        end
        default: tx_q <= 1'b1;
      endcase
    end
  end

  assign bus.tx      = tx_q;
  assign bus.busy    = busy_q;
  assign bus.full    = full_q;
  assign bus.overrun = overrun_q;
  assign bus.irq     = irq_q;
endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: writes push expected bytes, a line monitor decodes frames and pops.
module tb_uart_tx;
  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  byte unsigned sb_q[$];
  int           start_q[$];

  bit         m_act = 1'b0;
  int         m_n = 0;
  int         m_st = 0;
  logic [7:0] m_d = '0;

  uart_tx_if bus();

  uart_tx #(.WAIT_COUNT(W), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input bit expect_tx);
    bus.we      = 1'b1;
    bus.tx_data = d;
    if (expect_tx) sb_q.push_back(d);
    tick();
    bus.we = 1'b0;
  endtask

  task automatic pulse_ack();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (bus.busy && k < budget) begin
      tick();
      k++;
    end
    chk("idle_timeout_busy", int'(bus.busy), 0);
  endtask

  // Line monitor: samples mid-bit on the falling clock edge and checks decoded bytes in order.
  initial begin : monitor
    byte unsigned e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_act = 1'b0;
      end else if (!m_act) begin
        if (bus.tx == 1'b0) begin
          m_act = 1'b1;
          m_n   = 0;
          m_st  = cyc;
        end
      end else begin
        m_n++;
        if (m_n == W / 2) chk("mon_start_bit", int'(bus.tx), 0);
        for (int k = 0; k < 8; k++)
          if (m_n == W * (k + 1) + W / 2) m_d[k] = bus.tx;
        if (m_n == 9 * W + W / 2) begin
          chk("mon_stop_bit", int'(bus.tx), 1);
          m_act = 1'b0;
          start_q.push_back(m_st);
          if (sb_q.size() == 0) begin
            chk("sb_unexpected_frame", int'(m_d), 256);
          end else begin
            e = sb_q.pop_front();
            chk("sb_byte", int'(m_d), int'(e));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [9:0] fr;
    int t0;
    bit line_ok;

    rst = 1'b0;
    bus.we = 1'b0;
    bus.tx_data = '0;
    bus.ien = 1'b0;
    bus.ack = 1'b0;
    repeat (3) tick();
    chk("rst_tx", int'(bus.tx), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_irq", int'(bus.irq), 0);
    chk("rst_overrun", int'(bus.overrun), 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();

    // Single byte 0x55, cycle-exact line trace
    bus.ien = 1'b1;
    wr(8'h55, 1'b1);
    chk("enq_busy", int'(bus.busy), 1);
    chk("enq_tx_still_idle", int'(bus.tx), 1);
    fr = {1'b1, 8'h55, 1'b0};
    tick();
    for (int unsigned m = 0; m < 10 * W; m++) begin
      chk("single_tx_level", int'(fr[m / W]), int'(bus.tx)) ;
      if (m == 10 * W - 1) chk("single_busy_last", int'(bus.busy), 1);
      tick();
    end
    chk("single_done_busy", int'(bus.busy), 0);
    chk("single_done_irq", int'(bus.irq), 1);
    chk("single_done_tx", int'(bus.tx), 1);
    pulse_ack();
    chk("ack_clears_irq", int'(bus.irq), 0);

    // Back-to-back four bytes
    start_q.delete();
    wr(8'hA5, 1'b1);
    t0 = cyc;
    wr(8'h3C, 1'b1);
    wr(8'hFF, 1'b1);
    wr(8'h00, 1'b1);
    while (cyc < t0 + 40 * 4) tick();
    chk("b2b_irq_before_end", int'(bus.irq), 0);
    chk("b2b_busy_before_end", int'(bus.busy), 1);
    tick();
    chk("b2b_busy_end", int'(bus.busy), 0);
    chk("b2b_irq_end", int'(bus.irq), 1);
    chk("b2b_frames", start_q.size(), 4);
    for (int i = 1; i < start_q.size(); i++)
      chk("b2b_start_spacing", start_q[i] - start_q[i-1], 10 * W);
    chk("b2b_sb_drained", sb_q.size(), 0);
    pulse_ack();

    // Overflow during first frame
    wr(8'h01, 1'b1);
    wr(8'h02, 1'b1);
    wr(8'h03, 1'b1);
    wr(8'h04, 1'b1);
    wr(8'h05, 1'b1);
    chk("ovf_full", int'(bus.full), 1);
    chk("ovf_overrun_pre", int'(bus.overrun), 0);
    wr(8'h11, 1'b0);
    chk("ovf_full_after_drop", int'(bus.full), 1);
    chk("ovf_overrun_set", int'(bus.overrun), 1);
    pulse_ack();
    chk("ovf_ack_clears", int'(bus.overrun), 0);
    chk("ovf_full_kept", int'(bus.full), 1);
    wait_idle(300);
    chk("ovf_sb_drained", sb_q.size(), 0);
    chk("ovf_irq", int'(bus.irq), 1);
    pulse_ack();

    // ack coinciding with the idle event: set wins
    wr(8'h5A, 1'b1);
    t0 = cyc;
    while (cyc < t0 + 10 * W) tick();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("coinc_busy", int'(bus.busy), 0);
    chk("coinc_irq_set_wins", int'(bus.irq), 1);
    pulse_ack();
    chk("coinc_ack_later", int'(bus.irq), 0);

    // ien=0: no interrupt
    bus.ien = 1'b0;
    wr(8'h81, 1'b1);
    wait_idle(60);
    chk("noien_irq", int'(bus.irq), 0);

    // Push on the edge the FSM pops from a full FIFO
    wr(8'hB0, 1'b1);
    t0 = cyc;
    wr(8'hB1, 1'b1);
    wr(8'hB2, 1'b1);
    wr(8'hB3, 1'b1);
    wr(8'hB4, 1'b1);
    while (cyc < t0 + 10 * W) tick();
    chk("popfull_full_pre", int'(bus.full), 1);
    chk("popfull_overrun_pre", int'(bus.overrun), 0);
    wr(8'h77, 1'b0);
    chk("popfull_overrun", int'(bus.overrun), 1);
    chk("popfull_full_after", int'(bus.full), 0);
    wait_idle(250);
    chk("popfull_sb_drained", sb_q.size(), 0);
    pulse_ack();

    // Reset mid-frame
    bus.ien = 1'b1;
    wr(8'hC3, 1'b0);
    wr(8'h99, 1'b0);
    tick();
    tick();
    chk("midrst_pre_tx", int'(bus.tx), 0);
    #1 rst = 1'b0;
    #1;
    chk("midrst_async_tx", int'(bus.tx), 1);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_full", int'(bus.full), 0);
    @(negedge clk);
    rst = 1'b1;
    line_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) line_ok = 1'b0;
    end
    chk("midrst_fifo_discarded", int'(line_ok), 1);
    chk("midrst_irq", int'(bus.irq), 0);
    chk("final_sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-oriented UART transmitter with a small write FIFO: 8 data bits, no parity, 1 stop bit, LSB first. It sits beside the UART receiver in the peripheral block, and the CPU-side bus decode drives it through a single-cycle write strobe. It serialises queued bytes back-to-back onto the `tx` line. An optional interrupt fires when the transmitter drains to idle.

## Interface
- `WAIT_COUNT`, 868: clock cycles per bit (100 MHz / 115200 baud); legal range ≥ 2.
- `FIFO_DEPTH`, 4: byte entries in the write FIFO; power of two, ≥ 2.

- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `tx_data` in 8: byte to enqueue; sampled only when `we`=1.
- `we` in 1: write strobe; one byte is enqueued per cycle it is high and `full`=0.
- `ien` in 1: interrupt enable, sampled when the idle event occurs.
- `ack` in 1: clears `irq` and `overrun`.
- `tx` out 1: serial line; idle level is high.
- `busy` out 1: `state != IDLE` or FIFO count != 0.
- `full` out 1: FIFO count == `FIFO_DEPTH`.
- `overrun` out 1: sticky; a write was dropped because the FIFO was full.
- `irq` out 1: sticky transmit-done interrupt.

## Operation
- Reset (`rst`=0, asynchronous): state IDLE, FIFO count 0, read/write pointers 0, bit counter 0, wait counter 0, `tx`=1, `busy`=0, `full`=0, `overrun`=0, `irq`=0. Reset mid-frame aborts the frame immediately and discards queued bytes.
- FIFO: circular buffer, `$clog2(FIFO_DEPTH)`-bit pointers that wrap naturally, with a count of width `$clog2(FIFO_DEPTH)+1`.
  - Write when `we`=1 and registered `full`=0.
  - Write when `full`=1 is dropped even if a pop happens on the same edge, and `overrun` is set to 1.
  - A simultaneous push and pop leaves the count unchanged.
- State machine: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If count != 0, pop the head into the shift register, set `tx`=0 and go to START.
  - START: hold `tx`=0 for `WAIT_COUNT` cycles, then drive bit 0 and go to DATA with bit counter 0.
  - DATA: each bit is held `WAIT_COUNT` cycles. After bit 7 completes, set `tx`=1 and go to STOP.
  - STOP: hold `tx`=1 for `WAIT_COUNT` cycles. At the end:
    - If count != 0, pop the next byte, set `tx`=0 and go to START (no idle gap).
    - Otherwise go to IDLE and raise the idle event.
- Wait counter: counts 0 to `WAIT_COUNT`-1 and resets to 0 at each bit boundary; width `$clog2(WAIT_COUNT)`.
- Idle event: on the STOP→IDLE transition, if `ien`=1 then `irq` is set to 1.
- `ack`: clears `irq` and `overrun` on the next edge. If the idle event and `ack` coincide, `irq` stays 1 (set wins). If a drop and `ack` coincide, `overrun` stays 1.
- An accepted `we` does not clear `irq`.
- `tx` is a registered output and is glitch-free.

## Timing
- Enqueue latency: `we` sampled at edge E0 with an empty FIFO and state IDLE gives count=1 after E0 and `busy`=1 after E0. At E1 the FSM pops and `tx` falls after E1.
- Frame length: 10×`WAIT_COUNT` cycles from the `tx` falling edge to the end of the stop bit.
  - Start bit: E1 to E1+W.
  - Data bit k: E1+(k+1)·W to E1+(k+2)·W.
  - Stop bit: E1+9W to E1+10W.
- Back-to-back: the next start bit begins at exactly E1+10W.
- At E1+10W with an empty FIFO: state becomes IDLE, `busy`=0 and `irq`=1 (if `ien`=1), all visible after that edge.
- `full` and `overrun` update on the edge that changes the count.

## Test plan
Benches run with `WAIT_COUNT`=4 and `FIFO_DEPTH`=4.
- Reset values: hold `rst`=0 → `tx`=1, `busy`=0, `full`=0, `irq`=0, `overrun`=0. Assert `rst` mid-frame → `tx`=1 in the same cycle and the FIFO is empty after release.
- Single byte: write 0x55, `ien`=1 → `tx` = 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles. `tx` falls one edge after the write. After 40 cycles `busy`=0 and `irq`=1. `ack` → `irq`=0 next cycle.
- Back-to-back: write 0xA5, 0x3C, 0xFF, 0x00 on consecutive cycles → four frames, 160 cycles total, no idle high between a stop bit and the next start. `irq` is set once, at the end.
- Overflow: during the first frame, fill the FIFO and write 0x11 again → `full`=1 and `overrun`=1. 0x11 is not transmitted. `ack` clears `overrun`.
- Simultaneous events: `ack` on the same edge as the idle event → `irq`=1. With `ien`=0 → `irq` stays 0. Push on the same edge the FSM pops from a full FIFO → the write is dropped and `overrun`=1.
